// File: rtl/i2c_target_rx_pkg.sv
// i2c_target_rx_pkg: shared I2C FSM encodings, ACK/NACK levels and R/W bit position
package i2c_target_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;
    localparam int   RW_BIT = 0;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: multi-flop synchroniser on one bus pin with rise/fall pulses
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic D,
    output logic Q,
    output logic Rise,
    output logic Fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // shift the raw pin through the chain; flops idle high like a released bus
    always_ff @(posedge Clk) begin
        if (Rst) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], D};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign Q    = chain[SYNC_STAGES-1];
    assign Rise = Q & ~prev;
    assign Fall = ~Q & prev;

endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target receiver with address match, ACK drive and one-entry holding register
module i2c_target_rx
    import i2c_target_rx_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Scl,
    input  logic       Sda_in,
    output logic       Sda_oe,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       Busy,
    output logic       StopDet,
    output logic       Overrun
);

    logic       scl_s, scl_rise, scl_fall;
    logic       sda_s, sda_rise, sda_fall;
    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       ack_phase;
    logic       ack_bit;
    logic       sda_oe_r;
    logic       start_det;
    logic       stop_det;
    logic       accept;
    logic [7:0] byte_in;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .Clk  (Clk),
        .Rst  (Rst),
        .D    (Scl),
        .Q    (scl_s),
        .Rise (scl_rise),
        .Fall (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .Clk  (Clk),
        .Rst  (Rst),
        .D    (Sda_in),
        .Q    (sda_s),
        .Rise (sda_rise),
        .Fall (sda_fall)
    );

    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign accept    = !RxValid || RxReady;
    assign byte_in   = {shift, sda_s};
    // reset releases the pad in the same cycle it is asserted
    assign Sda_oe    = sda_oe_r & ~Rst;

    // bus FSM: START/STOP override everything, bits shift on SCL rise, ACK drive changes on SCL fall
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
            ack_phase <= 1'b0;
            ack_bit   <= NACK;
            sda_oe_r  <= 1'b0;
            RxData    <= 8'd0;
            RxValid   <= 1'b0;
            Busy      <= 1'b0;
            StopDet   <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            StopDet <= 1'b0;
            Overrun <= 1'b0;
            if (RxValid && RxReady)
                RxValid <= 1'b0;
            if (stop_det) begin
                state    <= ST_IDLE;
                Busy     <= 1'b0;
                StopDet  <= 1'b1;
                sda_oe_r <= 1'b0;
            end else if (start_det) begin
                state     <= ST_ADDR;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
                sda_oe_r  <= 1'b0;
                Busy      <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shift   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == ADDR && byte_in[RW_BIT] == 1'b0) begin
                                state   <= ST_ADDR_ACK;
                                Busy    <= 1'b1;
                                ack_bit <= ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_DATA: if (scl_rise) begin
                        shift   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_DATA_ACK;
                            if (accept) begin
                                RxData  <= byte_in;
                                RxValid <= 1'b1;
                                ack_bit <= ACK;
                            end else begin
                                Overrun <= 1'b1;
                                ack_bit <= NACK;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_r  <= (ack_bit == ACK);
                            ack_phase <= 1'b1;
                        end else begin
                            sda_oe_r  <= 1'b0;
                            ack_phase <= 1'b0;
                            bit_cnt   <= 3'd0;
                            state     <= ST_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: directed self-checking bench for the I2C target receiver
module tb_i2c_target_rx;

    localparam int Q = 10;
    localparam int H = 20;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Scl;
    logic       sda_drv;
    logic       Sda_in;
    logic       Sda_oe;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxReady;
    logic       Busy;
    logic       StopDet;
    logic       Overrun;

    int passed = 0;
    int total  = 0;
    int rxv_cycles, stop_cycles, ov_cycles, oe_cycles, busy_cycles;
    logic [7:0] last_rx;
    logic       ack;

    assign Sda_in = sda_drv & ~Sda_oe;

    always #5 Clk = ~Clk;

    i2c_target_rx #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Scl     (Scl),
        .Sda_in  (Sda_in),
        .Sda_oe  (Sda_oe),
        .RxData  (RxData),
        .RxValid (RxValid),
        .RxReady (RxReady),
        .Busy    (Busy),
        .StopDet (StopDet),
        .Overrun (Overrun)
    );

    // observe output activity away from the active edge
    always @(negedge Clk) begin
        if (RxValid) begin
            rxv_cycles++;
            last_rx = RxData;
        end
        if (StopDet) stop_cycles++;
        if (Overrun) ov_cycles++;
        if (Sda_oe) oe_cycles++;
        if (Busy) busy_cycles++;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        rxv_cycles = 0; stop_cycles = 0; ov_cycles = 0; oe_cycles = 0; busy_cycles = 0;
        last_rx = 8'hxx;
    endtask

    task automatic bus_start();
        sda_drv = 1'b0; hold(H);
        Scl = 1'b0; hold(Q);
    endtask

    task automatic bus_rstart();
        sda_drv = 1'b1; hold(Q);
        Scl = 1'b1; hold(H);
        sda_drv = 1'b0; hold(H);
        Scl = 1'b0; hold(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; hold(Q);
        Scl = 1'b1; hold(H);
        sda_drv = 1'b1; hold(H);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; hold(Q);
        Scl = 1'b1; hold(H);
        Scl = 1'b0; hold(Q);
    endtask

    task automatic get_ack(output logic a);
        sda_drv = 1'b1; hold(Q);
        Scl = 1'b1; hold(H / 2);
        a = Sda_in;
        hold(H / 2);
        Scl = 1'b0; hold(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        get_ack(a);
    endtask

    task automatic test_reset();
        Rst = 1'b1; Scl = 1'b1; sda_drv = 1'b1; RxReady = 1'b0;
        hold(5);
        total++; if (Sda_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", Sda_oe); else passed++;
        total++; if (RxData !== 8'h00) $display("FAIL reset_rxdata: got %h want 00", RxData); else passed++;
        total++; if (RxValid !== 1'b0) $display("FAIL reset_rxvalid: got %b want 0", RxValid); else passed++;
        total++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else passed++;
        total++; if (StopDet !== 1'b0) $display("FAIL reset_stopdet: got %b want 0", StopDet); else passed++;
        total++; if (Overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", Overrun); else passed++;
        Rst = 1'b0;
        hold(H);
    endtask

    task automatic test_write();
        RxReady = 1'b1;
        clr();
        bus_start();
        send_byte(8'h84, ack);
        total++; if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %b want 0", ack); else passed++;
        total++; if (Busy !== 1'b1) $display("FAIL wr_busy_on: got %b want 1", Busy); else passed++;
        send_byte(8'hA5, ack);
        total++; if (ack !== 1'b0) $display("FAIL wr_data_ack: got %b want 0", ack); else passed++;
        total++; if (last_rx !== 8'hA5) $display("FAIL wr_rxdata: got %h want a5", last_rx); else passed++;
        total++; if (rxv_cycles != 1) $display("FAIL wr_rxvalid_pulse: got %0d want 1", rxv_cycles); else passed++;
        bus_stop();
        total++; if (stop_cycles != 1) $display("FAIL wr_stopdet: got %0d want 1", stop_cycles); else passed++;
        total++; if (Busy !== 1'b0) $display("FAIL wr_busy_off: got %b want 0", Busy); else passed++;
    endtask

    task automatic test_wrong_addr();
        clr();
        bus_start();
        send_byte(8'h86, ack);
        total++; if (ack !== 1'b1) $display("FAIL wa_addr_nack: got %b want 1", ack); else passed++;
        send_byte(8'h5A, ack);
        total++; if (ack !== 1'b1) $display("FAIL wa_data_nack: got %b want 1", ack); else passed++;
        bus_stop();
        total++; if (oe_cycles != 0) $display("FAIL wa_no_drive: got %0d want 0", oe_cycles); else passed++;
        total++; if (rxv_cycles != 0) $display("FAIL wa_no_rx: got %0d want 0", rxv_cycles); else passed++;
        total++; if (busy_cycles != 0) $display("FAIL wa_no_busy: got %0d want 0", busy_cycles); else passed++;
    endtask

    task automatic test_read();
        clr();
        bus_start();
        send_byte(8'h85, ack);
        total++; if (ack !== 1'b1) $display("FAIL rd_addr_nack: got %b want 1", ack); else passed++;
        send_byte(8'hFF, ack);
        bus_stop();
        total++; if (oe_cycles != 0) $display("FAIL rd_no_drive: got %0d want 0", oe_cycles); else passed++;
        total++; if (busy_cycles != 0) $display("FAIL rd_no_busy: got %0d want 0", busy_cycles); else passed++;
        total++; if (stop_cycles != 1) $display("FAIL rd_stopdet: got %0d want 1", stop_cycles); else passed++;
    endtask

    task automatic test_overrun();
        RxReady = 1'b0;
        clr();
        bus_start();
        send_byte(8'h84, ack);
        send_byte(8'h11, ack);
        total++; if (ack !== 1'b0) $display("FAIL ov_first_ack: got %b want 0", ack); else passed++;
        send_byte(8'h22, ack);
        total++; if (ack !== 1'b1) $display("FAIL ov_second_nack: got %b want 1", ack); else passed++;
        send_byte(8'h33, ack);
        total++; if (ack !== 1'b1) $display("FAIL ov_third_nack: got %b want 1", ack); else passed++;
        bus_stop();
        total++; if (ov_cycles != 2) $display("FAIL ov_pulses: got %0d want 2", ov_cycles); else passed++;
        total++; if (RxValid !== 1'b1) $display("FAIL ov_held_valid: got %b want 1", RxValid); else passed++;
        total++; if (RxData !== 8'h11) $display("FAIL ov_held_data: got %h want 11", RxData); else passed++;
        RxReady = 1'b1;
        #1;
        total++; if (RxData !== 8'h11) $display("FAIL ov_ready_data: got %h want 11", RxData); else passed++;
        hold(1);
        total++; if (RxValid !== 1'b0) $display("FAIL ov_drain: got %b want 0", RxValid); else passed++;
    endtask

    task automatic test_partial();
        RxReady = 1'b1;
        clr();
        bus_start();
        send_byte(8'h84, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_stop();
        total++; if (rxv_cycles != 0) $display("FAIL pt_stop_no_rx: got %0d want 0", rxv_cycles); else passed++;
        clr();
        bus_start();
        send_byte(8'h84, ack);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        bus_rstart();
        total++; if (rxv_cycles != 0) $display("FAIL pt_rstart_no_rx: got %0d want 0", rxv_cycles); else passed++;
        send_byte(8'h84, ack);
        total++; if (ack !== 1'b0) $display("FAIL pt_addr_ack: got %b want 0", ack); else passed++;
        send_byte(8'h5A, ack);
        total++; if (ack !== 1'b0) $display("FAIL pt_data_ack: got %b want 0", ack); else passed++;
        bus_stop();
        total++; if (last_rx !== 8'h5A) $display("FAIL pt_rxdata: got %h want 5a", last_rx); else passed++;
        total++; if (rxv_cycles != 1) $display("FAIL pt_rx_count: got %0d want 1", rxv_cycles); else passed++;
    endtask

    task automatic test_reset_mid();
        RxReady = 1'b0;
        clr();
        bus_start();
        send_byte(8'h84, ack);
        for (int i = 7; i >= 0; i--) send_bit(1'b1);
        sda_drv = 1'b1; hold(Q);
        Scl = 1'b1; hold(2);
        total++; if (Sda_oe !== 1'b1) $display("FAIL rm_acking: got %b want 1", Sda_oe); else passed++;
        Rst = 1'b1;
        #1;
        total++; if (Sda_oe !== 1'b0) $display("FAIL rm_release_now: got %b want 0", Sda_oe); else passed++;
        hold(1);
        total++; if (Sda_oe !== 1'b0) $display("FAIL rm_oe: got %b want 0", Sda_oe); else passed++;
        total++; if (RxValid !== 1'b0) $display("FAIL rm_rxvalid: got %b want 0", RxValid); else passed++;
        total++; if (RxData !== 8'h00) $display("FAIL rm_rxdata: got %h want 00", RxData); else passed++;
        total++; if (Busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", Busy); else passed++;
        Rst = 1'b0;
        RxReady = 1'b1;
        hold(H);
        clr();
        bus_start();
        send_byte(8'h84, ack);
        total++; if (ack !== 1'b0) $display("FAIL rm_next_addr_ack: got %b want 0", ack); else passed++;
        send_byte(8'h3C, ack);
        bus_stop();
        total++; if (last_rx !== 8'h3C) $display("FAIL rm_next_rx: got %h want 3c", last_rx); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read();
        test_overrun();
        test_partial();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
